// File: rtl/i2s_pkg.sv
// Shared constants and elaboration helpers for the parametrised I2S/TDM transmitter.
package i2s_pkg;

    localparam logic MODE_I2S = 1'b0;
    localparam logic MODE_LJ  = 1'b1;

    // NCO step: two bck toggles per bit clock, SLOT_W bits per channel, CH channels per frame.
    function automatic logic [31:0] nco_inc(input int unsigned rate, input int unsigned ch,
                                            input int unsigned slot);
        longint unsigned prod;
        prod = 64'(rate) * 64'(ch) * 64'(slot) * 64'd2;
        return prod[31:0];
    endfunction

    function automatic bit params_ok(input int dw, input int sw, input int ch);
        return (dw >= 1) && (dw <= 32) && (sw >= dw) && (sw <= 32) &&
               (ch >= 2) && (ch <= 8) && ((ch % 2) == 0);
    endfunction

endpackage

// File: rtl/i2s_tdm_tx_nco.sv
// Fractional NCO: derives the bit clock from clk and flags a bck rate clk cannot support.
module i2s_tdm_tx_nco #(
    parameter logic [31:0] INC = 32'd6_144_000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic [31:0] clk_rate,
    output logic        bck,
    output logic        fall,
    output logic        cfg_err
);

    logic [32:0] acc;
    logic [32:0] sum;
    logic        over;
    logic        wrap;

    always_comb begin
        sum  = acc + {1'b0, INC};
        over = (INC >= clk_rate);
        wrap = over || (sum >= {1'b0, clk_rate});
    end

    assign fall = enable && wrap && bck;

    // When the rate is unreachable the accumulator is parked so it cannot overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc     <= '0;
            bck     <= 1'b0;
            cfg_err <= 1'b0;
        end else begin
            cfg_err <= over;
            if (!enable) begin
                acc <= '0;
                bck <= 1'b0;
            end else if (over) begin
                acc <= '0;
                bck <= ~bck;
            end else if (wrap) begin
                acc <= sum - {1'b0, clk_rate};
                bck <= ~bck;
            end else begin
                acc <= sum;
            end
        end
    end

endmodule

// File: rtl/i2s_tdm_tx.sv
// I2S / left-justified / TDM serial audio transmitter with a double-buffered frame input.
module i2s_tdm_tx
    import i2s_pkg::*;
#(
    parameter int DATA_W      = 16,
    parameter int SLOT_W      = 32,
    parameter int CHANNELS    = 2,
    parameter int SAMPLE_RATE = 48000
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic [31:0]                clk_rate,
    input  logic                       enable,
    input  logic                       mode,
    input  logic [CHANNELS*DATA_W-1:0] sample_data,
    input  logic                       sample_valid,
    output logic                       sample_ready,
    output logic                       bck,
    output logic                       ws,
    output logic                       sdata,
    output logic                       underrun,
    output logic                       cfg_err
);

    localparam int          F   = CHANNELS * SLOT_W;
    localparam int          BW  = $clog2(F);
    localparam int          FW  = CHANNELS * DATA_W;
    localparam logic [31:0] INC = nco_inc(SAMPLE_RATE, CHANNELS, SLOT_W);

    if (!params_ok(DATA_W, SLOT_W, CHANNELS)) begin : g_param_check
        $error("i2s_tdm_tx: DATA_W/SLOT_W/CHANNELS out of range");
    end

    logic [1:0]    rst_sync;
    logic          rst_n;
    logic          bck_fall;
    logic [BW-1:0] b;
    logic [BW-1:0] b_next;
    logic [BW-1:0] p_next;
    logic [FW-1:0] hold;
    logic [FW-1:0] shadow;
    logic [FW-1:0] src;
    logic [FW-1:0] shifted;
    logic          hold_full;
    logic          mode_r;
    logic          load;
    logic          ws_next;
    logic          sbit;
    int            slot;
    int            bitk;

    // Assertion is immediate; release is retimed to clk.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) rst_sync <= 2'b00;
        else          rst_sync <= {rst_sync[0], 1'b1};
    end
    assign rst_n = rst_sync[1];

    i2s_tdm_tx_nco #(.INC(INC)) u_nco (
        .clk      (clk),
        .rst_n    (rst_n),
        .enable   (enable),
        .clk_rate (clk_rate),
        .bck      (bck),
        .fall     (bck_fall),
        .cfg_err  (cfg_err)
    );

    assign sample_ready = !hold_full;

    always_comb begin
        b_next = (b == BW'(F - 1)) ? '0 : b + 1'b1;
        if (mode_r == MODE_LJ) p_next = b_next;
        else                   p_next = (b_next == '0) ? BW'(F - 1) : b_next - 1'b1;
        load    = bck_fall && (p_next == '0);
        // The bit that opens a frame already comes from the freshly loaded samples.
        src     = (load && hold_full) ? hold : shadow;
        slot    = int'(p_next) / SLOT_W;
        bitk    = int'(p_next) % SLOT_W;
        shifted = src >> (slot * DATA_W + DATA_W - 1 - bitk);
        sbit    = (bitk < DATA_W) ? shifted[0] : 1'b0;
        if (CHANNELS == 2)          ws_next = (b_next >= BW'(SLOT_W));
        else if (mode_r == MODE_LJ) ws_next = (b_next == '0);
        else                        ws_next = (b_next == BW'(F - 1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            b         <= '0;
            ws        <= 1'b0;
            sdata     <= 1'b0;
            underrun  <= 1'b0;
            hold      <= '0;
            hold_full <= 1'b0;
            shadow    <= '0;
            mode_r    <= MODE_I2S;
        end else begin
            underrun <= 1'b0;
            if (!enable) mode_r <= mode;
            if (sample_valid && !hold_full) begin
                hold      <= sample_data;
                hold_full <= 1'b1;
            end
            if (!enable) begin
                b     <= '0;
                ws    <= 1'b0;
                sdata <= 1'b0;
            end else if (bck_fall) begin
                b     <= b_next;
                ws    <= ws_next;
                sdata <= sbit;
                if (load) begin
                    if (hold_full) begin
                        shadow    <= hold;
                        hold_full <= 1'b0;
                    end else begin
                        underrun  <= 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_i2s_tdm_tx.sv
// Directed bench: a stereo I2S/LJ instance and a 4-channel TDM instance sharing clk and reset.
module tb_i2s_tdm_tx;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic reset_n = 1'b1;

    logic [31:0] clk_rate;
    logic        enable, mode, sample_valid;
    logic [31:0] sample_data;
    logic        sample_ready, bck, ws, sdata, underrun, cfg_err;

    logic [31:0] t_clk_rate;
    logic        t_enable, t_mode, t_sample_valid;
    logic [95:0] t_sample_data;
    logic        t_sample_ready, t_bck, t_ws, t_sdata, t_underrun, t_cfg_err;

    i2s_tdm_tx u_st (
        .clk(clk), .reset_n(reset_n), .clk_rate(clk_rate), .enable(enable), .mode(mode),
        .sample_data(sample_data), .sample_valid(sample_valid), .sample_ready(sample_ready),
        .bck(bck), .ws(ws), .sdata(sdata), .underrun(underrun), .cfg_err(cfg_err)
    );

    i2s_tdm_tx #(.DATA_W(24), .SLOT_W(32), .CHANNELS(4), .SAMPLE_RATE(48000)) u_tdm (
        .clk(clk), .reset_n(reset_n), .clk_rate(t_clk_rate), .enable(t_enable), .mode(t_mode),
        .sample_data(t_sample_data), .sample_valid(t_sample_valid), .sample_ready(t_sample_ready),
        .bck(t_bck), .ws(t_ws), .sdata(t_sdata), .underrun(t_underrun), .cfg_err(t_cfg_err)
    );

    int errors = 0;
    int checks = 0;
    bit s_ws_q[$], s_sd_q[$], t_ws_q[$], t_sd_q[$];
    int s_urun = 0, s_acc = 0, s_wsr = 0, t_urun = 0;
    logic s_bck_prev = 1'b0, s_ws_prev = 1'b0, t_bck_prev = 1'b0;

    // Receiver-style capture: one entry per bck rising edge.
    always @(negedge clk) begin
        if (bck && !s_bck_prev) begin s_ws_q.push_back(ws); s_sd_q.push_back(sdata); end
        s_bck_prev = bck;
        if (underrun) s_urun++;
        if (sample_valid && sample_ready) s_acc++;
        if (ws && !s_ws_prev) s_wsr++;
        s_ws_prev = ws;
        if (t_bck && !t_bck_prev) begin t_ws_q.push_back(t_ws); t_sd_q.push_back(t_sdata); end
        t_bck_prev = t_bck;
        if (t_underrun) t_urun++;
    end

    function automatic logic [31:0] s_word(input int base);
        logic [31:0] w = '0;
        for (int j = 0; j < 32; j++) w = {w[30:0], s_sd_q[base + j]};
        return w;
    endfunction

    function automatic logic [31:0] t_word(input int base);
        logic [31:0] w = '0;
        for (int j = 0; j < 32; j++) w = {w[30:0], t_sd_q[base + j]};
        return w;
    endfunction

    task automatic wait_s(input int n);
        int cyc = 0;
        while (s_sd_q.size() < n && cyc < 20000) begin @(posedge clk); cyc++; end
        checks++;
        if (s_sd_q.size() < n) begin errors++; $display("FAIL wait_s: got %0d bits, want %0d", s_sd_q.size(), n); end
    endtask

    task automatic wait_t(input int n);
        int cyc = 0;
        while (t_sd_q.size() < n && cyc < 20000) begin @(posedge clk); cyc++; end
        checks++;
        if (t_sd_q.size() < n) begin errors++; $display("FAIL wait_t: got %0d bits, want %0d", t_sd_q.size(), n); end
    endtask

    task automatic wait_phase(input int m);
        int cyc = 0;
        while (((s_sd_q.size() - 1) % 64) != m && cyc < 2000) begin @(posedge clk); cyc++; end
        checks++;
        if (((s_sd_q.size() - 1) % 64) != m) begin errors++; $display("FAIL wait_phase: got %0d want %0d", (s_sd_q.size() - 1) % 64, m); end
    endtask

    task automatic send_s(input logic [31:0] d);
        int cyc = 0;
        sample_data = d; sample_valid = 1'b1;
        @(negedge clk);
        while (!sample_ready && cyc < 2000) begin @(negedge clk); cyc++; end
        @(posedge clk); #1 sample_valid = 1'b0;
        checks++;
        if (cyc >= 2000) begin errors++; $display("FAIL send_s: accept timeout got ready=%b want 1", sample_ready); end
    endtask

    task automatic send_t(input logic [95:0] d);
        int cyc = 0;
        t_sample_data = d; t_sample_valid = 1'b1;
        @(negedge clk);
        while (!t_sample_ready && cyc < 2000) begin @(negedge clk); cyc++; end
        @(posedge clk); #1 t_sample_valid = 1'b0;
        checks++;
        if (cyc >= 2000) begin errors++; $display("FAIL send_t: accept timeout got ready=%b want 1", t_sample_ready); end
    endtask

    task automatic test_reset();
        #2 reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks += 7;
        if (bck !== 1'b0)            begin errors++; $display("FAIL rst_bck: got %b want 0", bck); end
        if (ws !== 1'b0)             begin errors++; $display("FAIL rst_ws: got %b want 0", ws); end
        if (sdata !== 1'b0)          begin errors++; $display("FAIL rst_sdata: got %b want 0", sdata); end
        if (underrun !== 1'b0)       begin errors++; $display("FAIL rst_underrun: got %b want 0", underrun); end
        if (cfg_err !== 1'b0)        begin errors++; $display("FAIL rst_cfg_err: got %b want 0", cfg_err); end
        if (sample_ready !== 1'b1)   begin errors++; $display("FAIL rst_ready: got %b want 1", sample_ready); end
        if (t_sample_ready !== 1'b1) begin errors++; $display("FAIL rst_t_ready: got %b want 1", t_sample_ready); end
        @(negedge clk) reset_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic test_i2s_stereo();
        int u, r1, r2, bad;
        s_ws_q.delete(); s_sd_q.delete(); s_urun = 0;
        send_s({16'h0F5A, 16'hA5F0});
        checks += 2;
        if (sample_ready !== 1'b0) begin errors++; $display("FAIL i2s_hold_full: got ready=%b want 0", sample_ready); end
        if (cfg_err !== 1'b0)      begin errors++; $display("FAIL i2s_cfg_err: got %b want 0", cfg_err); end
        @(posedge clk); #1 enable = 1'b1;
        wait_s(193);
        u = s_urun;
        for (int f = 0; f < 3; f++) begin
            checks += 2;
            if (s_word(64*f + 1) !== 32'hA5F0_0000)  begin errors++; $display("FAIL i2s_left f%0d: got %h want a5f00000", f, s_word(64*f + 1)); end
            if (s_word(64*f + 33) !== 32'h0F5A_0000) begin errors++; $display("FAIL i2s_right f%0d: got %h want 0f5a0000", f, s_word(64*f + 33)); end
        end
        bad = 0;
        for (int i = 0; i < 192; i++) if (s_ws_q[i] !== ((i % 64) >= 32)) bad++;
        checks++;
        if (bad != 0) begin errors++; $display("FAIL i2s_ws_pattern: got %0d wrong bits want 0", bad); end
        r1 = -1; r2 = -1;
        for (int i = 1; i < 192; i++) if (s_ws_q[i] && !s_ws_q[i-1]) begin if (r1 < 0) r1 = i; else if (r2 < 0) r2 = i; end
        checks++;
        if (r2 - r1 != 64) begin errors++; $display("FAIL i2s_bck_per_ws: got %0d want 64", r2 - r1); end
        checks += 2;
        if (s_sd_q[0] !== 1'b0 || s_sd_q[64] !== 1'b0) begin errors++; $display("FAIL i2s_pad_bit: got %b%b want 00", s_sd_q[0], s_sd_q[64]); end
        if (u != 2) begin errors++; $display("FAIL i2s_underrun_count: got %0d want 2", u); end
    endtask

    task automatic test_backpressure();
        int base;
        wait_phase(32);
        #1;
        sample_data = {16'h1234, 16'h8001}; sample_valid = 1'b1;
        s_acc = 0; s_urun = 0;
        base = s_sd_q.size() - 1;
        wait_s(base + 193);
        checks += 5;
        if (s_acc != 4)             begin errors++; $display("FAIL bp_accepts: got %0d want 4", s_acc); end
        if (s_urun != 0)            begin errors++; $display("FAIL bp_underrun: got %0d want 0", s_urun); end
        if (sample_ready !== 1'b0)  begin errors++; $display("FAIL bp_ready_low: got %b want 0", sample_ready); end
        if (s_word(base + 33) !== 32'h8001_0000) begin errors++; $display("FAIL bp_left: got %h want 80010000", s_word(base + 33)); end
        if (s_word(base + 65) !== 32'h1234_0000) begin errors++; $display("FAIL bp_right: got %h want 12340000", s_word(base + 65)); end
        @(posedge clk); #1 sample_valid = 1'b0;
    endtask

    task automatic test_reset_midframe();
        int r1;
        wait_phase(45);
        @(posedge clk); #3 reset_n = 1'b0;
        #1;
        checks += 6;
        if (bck !== 1'b0)          begin errors++; $display("FAIL mid_rst_bck: got %b want 0", bck); end
        if (ws !== 1'b0)           begin errors++; $display("FAIL mid_rst_ws: got %b want 0", ws); end
        if (sdata !== 1'b0)        begin errors++; $display("FAIL mid_rst_sdata: got %b want 0", sdata); end
        if (underrun !== 1'b0)     begin errors++; $display("FAIL mid_rst_underrun: got %b want 0", underrun); end
        if (cfg_err !== 1'b0)      begin errors++; $display("FAIL mid_rst_cfg_err: got %b want 0", cfg_err); end
        if (sample_ready !== 1'b1) begin errors++; $display("FAIL mid_rst_ready: got %b want 1", sample_ready); end
        s_ws_q.delete(); s_sd_q.delete();
        @(negedge clk) reset_n = 1'b1;
        wait_s(40);
        r1 = -1;
        for (int i = 0; i < 40; i++) if (r1 < 0 && s_ws_q[i]) r1 = i;
        checks += 3;
        if (r1 != 32)               begin errors++; $display("FAIL mid_rst_restart: ws rise at %0d want 32", r1); end
        if (s_sd_q[0] !== 1'b0)     begin errors++; $display("FAIL mid_rst_first_bit: got %b want 0", s_sd_q[0]); end
        if (sample_ready !== 1'b1)  begin errors++; $display("FAIL mid_rst_ready_after: got %b want 1", sample_ready); end
    endtask

    task automatic test_left_justified();
        @(posedge clk); #1 enable = 1'b0; mode = 1'b1;
        repeat (2) @(posedge clk); #1;
        send_s({16'h0F5A, 16'hA5F0});
        s_ws_q.delete(); s_sd_q.delete(); s_urun = 0;
        @(posedge clk); #1 enable = 1'b1;
        repeat (3) @(posedge clk); #1 mode = 1'b0;
        wait_s(193);
        checks += 6;
        if (s_word(64) !== 32'hA5F0_0000)  begin errors++; $display("FAIL lj_left: got %h want a5f00000", s_word(64)); end
        if (s_word(96) !== 32'h0F5A_0000)  begin errors++; $display("FAIL lj_right: got %h want 0f5a0000", s_word(96)); end
        if (s_ws_q[95] !== 1'b0 || s_ws_q[96] !== 1'b1) begin errors++; $display("FAIL lj_ws_edge: got %b%b want 01", s_ws_q[95], s_ws_q[96]); end
        if (s_ws_q[64] !== 1'b0 || s_ws_q[63] !== 1'b1) begin errors++; $display("FAIL lj_ws_fall: got %b%b want 10", s_ws_q[63], s_ws_q[64]); end
        if (s_word(128) !== 32'hA5F0_0000) begin errors++; $display("FAIL lj_mode_held: got %h want a5f00000", s_word(128)); end
        if (s_urun != 2)                   begin errors++; $display("FAIL lj_underrun_count: got %0d want 2", s_urun); end
    endtask

    task automatic test_rate();
        int n;
        @(posedge clk); s_wsr = 0;
        repeat (28000) @(posedge clk);
        n = s_wsr;
        checks += 2;
        if (n < 95 || n > 97) begin errors++; $display("FAIL rate_ws_periods: got %0d want 96+-1", n); end
        if (cfg_err !== 1'b0) begin errors++; $display("FAIL rate_cfg_err: got %b want 0", cfg_err); end
    endtask

    task automatic test_cfg_err();
        int n = 0;
        logic prev;
        @(posedge clk); #1 clk_rate = 32'd5_000_000;
        repeat (2) @(posedge clk); #1;
        checks++;
        if (cfg_err !== 1'b1) begin errors++; $display("FAIL cfg_err_set: got %b want 1", cfg_err); end
        prev = bck;
        repeat (8) begin @(posedge clk); #1; if (bck !== prev) n++; prev = bck; end
        checks++;
        if (n != 8) begin errors++; $display("FAIL cfg_bck_every_cycle: got %0d toggles want 8", n); end
        clk_rate = 32'd14_000_000;
        repeat (2) @(posedge clk); #1;
        checks++;
        if (cfg_err !== 1'b0) begin errors++; $display("FAIL cfg_err_clear: got %b want 0", cfg_err); end
    endtask

    task automatic test_tdm();
        logic [31:0] texp [4];
        int u, bad, r1, r2;
        texp[0] = 32'h8000_0100; texp[1] = 32'h7FFF_FF00; texp[2] = 32'h0000_0000; texp[3] = 32'hFFFF_FF00;
        send_t({24'hFFFFFF, 24'h000000, 24'h7FFFFF, 24'h800001});
        t_ws_q.delete(); t_sd_q.delete(); t_urun = 0;
        @(posedge clk); #1 t_enable = 1'b1;
        wait_t(257);
        u = t_urun;
        for (int s = 0; s < 4; s++) begin
            checks++;
            if (t_word(129 + 32*s) !== texp[s]) begin errors++; $display("FAIL tdm_slot%0d: got %h want %h", s, t_word(129 + 32*s), texp[s]); end
        end
        bad = 0;
        for (int i = 0; i < 256; i++) if (t_ws_q[i] !== ((i % 128) == 127)) bad++;
        r1 = -1; r2 = -1;
        for (int i = 1; i < 256; i++) if (t_ws_q[i] && !t_ws_q[i-1]) begin if (r1 < 0) r1 = i; else if (r2 < 0) r2 = i; end
        checks += 4;
        if (bad != 0)           begin errors++; $display("FAIL tdm_ws_pulse: got %0d wrong bits want 0", bad); end
        if (r2 - r1 != 128)     begin errors++; $display("FAIL tdm_frame_len: got %0d want 128", r2 - r1); end
        if (u != 1)             begin errors++; $display("FAIL tdm_underrun: got %0d want 1", u); end
        if (t_cfg_err !== 1'b0) begin errors++; $display("FAIL tdm_cfg_err: got %b want 0", t_cfg_err); end
    endtask

    initial begin
        clk_rate = 32'd14_000_000; enable = 1'b0; mode = 1'b0; sample_valid = 1'b0; sample_data = '0;
        t_clk_rate = 32'd14_000_000; t_enable = 1'b0; t_mode = 1'b0; t_sample_valid = 1'b0; t_sample_data = '0;
        test_reset();
        test_i2s_stereo();
        test_backpressure();
        test_reset_midframe();
        test_left_justified();
        test_rate();
        test_cfg_err();
        test_tdm();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
